// File: rtl/rhythm_pkg.sv
// Shared encodings for the rhythm-game hit judge: grade codes, FSM states and point values.
package rhythm_pkg;

  localparam logic [1:0] GRADE_MISS    = 2'b00;
  localparam logic [1:0] GRADE_GOOD    = 2'b01;
  localparam logic [1:0] GRADE_PERFECT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [2:0] PTS_PERFECT = 3'd3;
  localparam logic [2:0] PTS_GOOD    = 3'd1;
  localparam logic [2:0] PTS_MISS    = 3'd0;
  localparam logic [2:0] STREAK_MULT = 3'd2;

  function automatic logic [2:0] grade_points(input logic [1:0] grade);
    case (grade)
      GRADE_PERFECT: return PTS_PERFECT;
      GRADE_GOOD:    return PTS_GOOD;
      default:       return PTS_MISS;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus registered falling-edge detect on the active-low button.
// press_o pulses for one cycle, three clocks after btn_n_i falls.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  logic s1_q, s2_q, prev_q, press_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn_n_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      press_q <= prev_q & ~s2_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/hit_judge.sv
// Times a button press against a note window, grades it, and keeps score and streak.
// Optional HIT_JUDGE_STREAK_EN: keeps a streak counter and doubles points once streak >= 8.
module hit_judge
  import rhythm_pkg::*;
#(
  parameter int WINDOW_CYC  = 50000000,
  parameter int PERFECT_CYC = 5000000,
  parameter int GOOD_CYC    = 15000000,
  parameter int CNT_W       = 26,
  parameter int SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               note_start,
  input  logic               btn_n,
  output logic               hit_valid,
  output logic [1:0]         hit_grade,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         streak,
  output logic               busy
);

  localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WINDOW_CYC);
  localparam logic [CNT_W-1:0] PERF_C = CNT_W'(PERFECT_CYC);
  localparam logic [CNT_W-1:0] GOOD_C = CNT_W'(GOOD_CYC);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(WINDOW_CYC + GOOD_CYC);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         grade_q, grade_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               press;
  logic               judge;
  logic [CNT_W-1:0]   err;
  logic [1:0]         press_grade;
  logic [2:0]         pts;
  logic [3:0]         inc;
  logic [SCORE_W:0]   sum;

  btn_sync_edge u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_n),
    .press_o (press)
  );

  always_comb begin
    err = (cnt_q >= WIN_C) ? (cnt_q - WIN_C) : (WIN_C - cnt_q);
    if (err <= PERF_C)      press_grade = GRADE_PERFECT;
    else if (err <= GOOD_C) press_grade = GRADE_GOOD;
    else                    press_grade = GRADE_MISS;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grade_d = grade_q;
    judge   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (note_start) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end
      end
      ST_ACTIVE: begin
        // A press in the timeout cycle still counts as a press.
        if (press) begin
          judge   = 1'b1;
          grade_d = press_grade;
          state_d = ST_REPORT;
        end else if (cnt_q == TMO_C) begin
          judge   = 1'b1;
          grade_d = GRADE_MISS;
          state_d = ST_REPORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign pts = grade_points(grade_d);

`ifdef HIT_JUDGE_STREAK_EN
  logic [7:0] streak_q, streak_d;

  always_comb begin
    inc      = (streak_q >= 8'd8) ? ({1'b0, pts} * {1'b0, STREAK_MULT}) : {1'b0, pts};
    streak_d = streak_q;
    if (judge) begin
      if (grade_d == GRADE_MISS)  streak_d = 8'd0;
      else if (streak_q != 8'hFF) streak_d = streak_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) streak_q <= 8'd0;
    else      streak_q <= streak_d;
  end

  assign streak = streak_q;
`else
  assign inc    = {1'b0, pts};
  assign streak = 8'd0;
`endif

  always_comb begin
    sum     = {1'b0, score_q} + (SCORE_W+1)'(inc);
    score_d = score_q;
    if (judge) score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grade_q <= GRADE_MISS;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grade_q <= grade_d;
      score_q <= score_d;
    end
  end

  assign hit_valid = (state_q == ST_REPORT);
  assign hit_grade = hit_valid ? grade_q : GRADE_MISS;
  assign busy      = (state_q != ST_IDLE);
  assign score     = score_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with a 100-cycle window, perfect +-5, good +-15.
module tb_hit_judge;

`ifdef HIT_JUDGE_STREAK_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        note_start = 1'b0;
  logic        btn_n = 1'b1;
  logic        hit_valid;
  logic [1:0]  hit_grade;
  logic [15:0] score;
  logic [7:0]  streak;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic        obs_vld;
  logic [1:0]  obs_grade;
  logic [15:0] obs_score;
  logic [7:0]  obs_streak;
  int          early;

  hit_judge #(
    .WINDOW_CYC (100),
    .PERFECT_CYC(5),
    .GOOD_CYC   (15),
    .CNT_W      (8),
    .SCORE_W    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .note_start(note_start),
    .btn_n     (btn_n),
    .hit_valid (hit_valid),
    .hit_grade (hit_grade),
    .score     (score),
    .streak    (streak),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Plays one note from IDLE. k: counter value at which the press is seen (-1 = no press).
  // restart_at: counter value at which a stray note_start is pulsed (-1 = none).
  // Returns sampled outputs in the REPORT cycle; early counts hit_valid seen before it.
  task automatic play_note(input int k, input int restart_at);
    int rep;
    rep = (k >= 0) ? k + 1 : 116;
    early = 0;
    note_start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < rep; c++) begin
      if (hit_valid === 1'b1) early++;
      note_start = (c == restart_at);
      if (k >= 0 && c == k - 3) btn_n = 1'b0;
      @(negedge clk);
    end
    obs_vld    = hit_valid;
    obs_grade  = hit_grade;
    obs_score  = score;
    obs_streak = streak;
    btn_n      = 1'b1;
    note_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 5;
    if (hit_valid !== 1'b0) begin errors++; $display("FAIL reset_hit_valid got %0b want 0", hit_valid); end
    if (hit_grade !== 2'd0) begin errors++; $display("FAIL reset_hit_grade got %0d want 0", hit_grade); end
    if (score !== 16'd0)    begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    if (streak !== 8'd0)    begin errors++; $display("FAIL reset_streak got %0d want 0", streak); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_perfect;
    play_note(100, -1);
    checks += 5;
    if (early !== 0)            begin errors++; $display("FAIL perfect_latency early hit_valid count %0d want 0", early); end
    if (obs_vld !== 1'b1)       begin errors++; $display("FAIL perfect_valid got %0b want 1", obs_vld); end
    if (obs_grade !== 2'b10)    begin errors++; $display("FAIL perfect_grade got %0d want 2", obs_grade); end
    if (obs_score !== 16'd3)    begin errors++; $display("FAIL perfect_score got %0d want 3", obs_score); end
    if (obs_streak !== (SEN ? 8'd1 : 8'd0)) begin
      errors++; $display("FAIL perfect_streak got %0d want %0d", obs_streak, SEN ? 1 : 0);
    end
  endtask

  task automatic test_boundaries;
    int         ks[4]      = '{105, 106, 115, 84};
    logic [1:0] grades[4]  = '{2'b10, 2'b01, 2'b01, 2'b00};
    int         scores[4]  = '{6, 7, 8, 8};
    int         streaks[4] = '{2, 3, 4, 0};
    for (int i = 0; i < 4; i++) begin
      play_note(ks[i], -1);
      checks += 4;
      if (obs_vld !== 1'b1) begin errors++; $display("FAIL bound_valid cnt=%0d got %0b want 1", ks[i], obs_vld); end
      if (obs_grade !== grades[i]) begin
        errors++; $display("FAIL bound_grade cnt=%0d got %0d want %0d", ks[i], obs_grade, grades[i]);
      end
      if (obs_score !== 16'(scores[i])) begin
        errors++; $display("FAIL bound_score cnt=%0d got %0d want %0d", ks[i], obs_score, scores[i]);
      end
      if (obs_streak !== (SEN ? 8'(streaks[i]) : 8'd0)) begin
        errors++; $display("FAIL bound_streak cnt=%0d got %0d want %0d", ks[i], obs_streak, SEN ? streaks[i] : 0);
      end
    end
  endtask

  task automatic test_timeout;
    play_note(-1, -1);
    checks += 4;
    if (early !== 0)         begin errors++; $display("FAIL timeout_early hit_valid count %0d want 0", early); end
    if (obs_vld !== 1'b1)    begin errors++; $display("FAIL timeout_valid got %0b want 1", obs_vld); end
    if (obs_grade !== 2'b00) begin errors++; $display("FAIL timeout_grade got %0d want 0", obs_grade); end
    if (obs_score !== 16'd8) begin errors++; $display("FAIL timeout_score got %0d want 8", obs_score); end
  endtask

  task automatic test_press_at_timeout;
    int extra;
    play_note(115, -1);
    extra = 0;
    repeat (5) begin
      if (hit_valid === 1'b1) extra++;
      @(negedge clk);
    end
    checks += 5;
    if (obs_vld !== 1'b1)    begin errors++; $display("FAIL pt_valid got %0b want 1", obs_vld); end
    if (obs_grade !== 2'b01) begin errors++; $display("FAIL pt_grade got %0d want 1", obs_grade); end
    if (obs_score !== 16'd9) begin errors++; $display("FAIL pt_score got %0d want 9", obs_score); end
    if (obs_streak !== (SEN ? 8'd1 : 8'd0)) begin
      errors++; $display("FAIL pt_streak got %0d want %0d", obs_streak, SEN ? 1 : 0);
    end
    if (extra !== 0) begin errors++; $display("FAIL pt_second_valid got %0d pulses want 0", extra); end
  endtask

  task automatic test_ignored;
    int vld_seen;
    int busy_seen;
    play_note(100, 40);
    checks += 4;
    if (early !== 0)          begin errors++; $display("FAIL restart_early hit_valid count %0d want 0", early); end
    if (obs_grade !== 2'b10)  begin errors++; $display("FAIL restart_grade got %0d want 2", obs_grade); end
    if (obs_score !== 16'd12) begin errors++; $display("FAIL restart_score got %0d want 12", obs_score); end
    if (obs_streak !== (SEN ? 8'd2 : 8'd0)) begin
      errors++; $display("FAIL restart_streak got %0d want %0d", obs_streak, SEN ? 2 : 0);
    end
    vld_seen = 0;
    busy_seen = 0;
    btn_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (hit_valid === 1'b1) vld_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    btn_n = 1'b1;
    repeat (4) @(negedge clk);
    checks += 3;
    if (vld_seen !== 0)   begin errors++; $display("FAIL idle_press_valid got %0d pulses want 0", vld_seen); end
    if (busy_seen !== 0)  begin errors++; $display("FAIL idle_press_busy got %0d cycles want 0", busy_seen); end
    if (score !== 16'd12) begin errors++; $display("FAIL idle_press_score got %0d want 12", score); end
  endtask

  task automatic test_mid_reset;
    int vld_seen;
    int busy_seen;
    note_start = 1'b1;
    @(negedge clk);
    note_start = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b0;
    #1;
    checks += 5;
    if (hit_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %0b want 0", hit_valid); end
    if (hit_grade !== 2'd0) begin errors++; $display("FAIL mid_reset_grade got %0d want 0", hit_grade); end
    if (score !== 16'd0)    begin errors++; $display("FAIL mid_reset_score got %0d want 0", score); end
    if (streak !== 8'd0)    begin errors++; $display("FAIL mid_reset_streak got %0d want 0", streak); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_reset_busy got %0b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    vld_seen = 0;
    busy_seen = 0;
    repeat (4) @(negedge clk);
    btn_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (hit_valid === 1'b1) vld_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    btn_n = 1'b1;
    repeat (4) @(negedge clk);
    checks += 2;
    if (busy_seen !== 0) begin errors++; $display("FAIL after_reset_busy got %0d cycles want 0", busy_seen); end
    if (vld_seen !== 0)  begin errors++; $display("FAIL after_reset_valid got %0d pulses want 0", vld_seen); end
  endtask

  task automatic test_streak;
    for (int i = 0; i < 9; i++) play_note(100, -1);
    checks += 2;
    if (score !== (SEN ? 16'd30 : 16'd27)) begin
      errors++; $display("FAIL streak_score got %0d want %0d", score, SEN ? 30 : 27);
    end
    if (streak !== (SEN ? 8'd9 : 8'd0)) begin
      errors++; $display("FAIL streak_count got %0d want %0d", streak, SEN ? 9 : 0);
    end
  endtask

  initial begin
    test_reset;
    test_perfect;
    test_boundaries;
    test_timeout;
    test_press_at_timeout;
    test_ignored;
    test_mid_reset;
    test_streak;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
